// File: rtl/average_round_sequencer.sv
// average_round_sequencer
//   Controller for the waveform averaging unit. Runs a programmed number of
//   averaging rounds (arm -> wait for records -> readout -> count beats ->
//   optional gap) without host intervention, with a per-wait watchdog.
//
// Optional feature macro: AVG_SEQ_SWTRIG_EN
//   When defined, adds swtrig_period_i / sw_trig_o: a periodic software
//   trigger pulse generated while waiting for records.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   start_i, abort_i          one-cycle host commands (abort has priority)
//   nof_*_i, gap_cycles_i,
//   timeout_cycles_i          run configuration, latched on an accepted start
//   avg_*_i                   averager status (available, records, beat valid)
//   avg_arm_o/readout_o/
//   shutdown_o                one-cycle strobes to the averager
//   busy_o, done_o, timeout_o host status (timeout_o is sticky until next start)
//   round_count_o             rounds completed in the current/last run
//   state_o                   current state encoding
module average_round_sequencer #(
  parameter int TimeoutWidth = 24,
  parameter int CountWidth   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [CountWidth-1:0]   nof_rounds_i,
  input  logic [CountWidth-1:0]   nof_waveforms_i,
  input  logic [CountWidth-1:0]   nof_sample_cycles_i,
  input  logic [CountWidth-1:0]   gap_cycles_i,
  input  logic [TimeoutWidth-1:0] timeout_cycles_i,
  input  logic                    avg_data_available_i,
  input  logic [CountWidth-1:0]   avg_records_collected_i,
  input  logic                    avg_data_valid_i,
`ifdef AVG_SEQ_SWTRIG_EN
  input  logic [CountWidth-1:0]   swtrig_period_i,
  output logic                    sw_trig_o,
`endif
  output logic                    avg_arm_o,
  output logic                    avg_readout_o,
  output logic                    avg_shutdown_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic [CountWidth-1:0]   round_count_o,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ARM          = 3'd1,
    WAIT_COLLECT = 3'd2,
    READOUT      = 3'd3,
    WAIT_READOUT = 3'd4,
    GAP          = 3'd5,
    DONE         = 3'd6
  } state_t;

  localparam logic [CountWidth-1:0] CNT_ONE = {{(CountWidth-1){1'b0}}, 1'b1};

  state_t                  state, state_nx;
  logic [CountWidth-1:0]   cfg_rounds, cfg_waves, cfg_samples, cfg_gap;
  logic [TimeoutWidth-1:0] cfg_timeout;
  logic [TimeoutWidth-1:0] wd, wd_nx, wd_inc;
  logic [CountWidth-1:0]   beats, beats_nx, beat_inc;
  logic [CountWidth-1:0]   gap_cnt, gap_nx;
  logic [CountWidth-1:0]   rounds_nx, rounds_inc;
  logic                    timeout_nx, shutdown_nx, latch, wd_expired;

  assign wd_inc     = wd + 1'b1;
  assign beat_inc   = beats + 1'b1;
  assign rounds_inc = (&round_count_o) ? round_count_o : round_count_o + 1'b1;
  // Watchdog fires on the cycle its count would reach the limit, so a wait
  // state lasts exactly cfg_timeout cycles before the shutdown pulse.
  assign wd_expired = (cfg_timeout != '0) && (wd_inc == cfg_timeout);

  always_comb begin
    state_nx    = state;
    wd_nx       = wd;
    beats_nx    = beats;
    gap_nx      = gap_cnt;
    rounds_nx   = round_count_o;
    timeout_nx  = timeout_o;
    shutdown_nx = 1'b0;
    latch       = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          latch      = 1'b1;
          rounds_nx  = '0;
          timeout_nx = 1'b0;
          state_nx   = ARM;
        end
      end
      ARM: begin
        wd_nx    = '0;
        state_nx = WAIT_COLLECT;
      end
      WAIT_COLLECT: begin
        wd_nx = wd_inc;
        if (wd_expired) begin
          timeout_nx  = 1'b1;
          shutdown_nx = 1'b1;
          state_nx    = IDLE;
        end else if (avg_data_available_i && (avg_records_collected_i >= cfg_waves)) begin
          state_nx = READOUT;
        end
      end
      READOUT: begin
        beats_nx = '0;
        wd_nx    = '0;
        state_nx = WAIT_READOUT;
      end
      WAIT_READOUT: begin
        wd_nx = wd_inc;
        if (wd_expired) begin
          timeout_nx  = 1'b1;
          shutdown_nx = 1'b1;
          state_nx    = IDLE;
        end else if (avg_data_valid_i) begin
          beats_nx = beat_inc;
          if (beat_inc == cfg_samples) begin
            rounds_nx = rounds_inc;
            gap_nx    = '0;
            if (rounds_inc == cfg_rounds) state_nx = DONE;
            else if (cfg_gap == '0)       state_nx = ARM;  // no gap: re-arm at once
            else                          state_nx = GAP;
          end
        end
      end
      GAP: begin
        gap_nx = gap_cnt + 1'b1;
        if (gap_nx == cfg_gap) state_nx = ARM;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle timeout or round end.
    if (abort_i && (state != IDLE)) begin
      state_nx    = IDLE;
      shutdown_nx = 1'b1;
      rounds_nx   = round_count_o;
      timeout_nx  = timeout_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      wd             <= '0;
      beats          <= '0;
      gap_cnt        <= '0;
      cfg_rounds     <= '0;
      cfg_waves      <= '0;
      cfg_samples    <= '0;
      cfg_gap        <= '0;
      cfg_timeout    <= '0;
      round_count_o  <= '0;
      timeout_o      <= 1'b0;
      avg_arm_o      <= 1'b0;
      avg_readout_o  <= 1'b0;
      avg_shutdown_o <= 1'b0;
      done_o         <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_nx;
      wd             <= wd_nx;
      beats          <= beats_nx;
      gap_cnt        <= gap_nx;
      round_count_o  <= rounds_nx;
      timeout_o      <= timeout_nx;
      // Strobes are registered images of the state being entered, so each is
      // high for exactly the one cycle spent in ARM / READOUT / DONE.
      avg_arm_o      <= (state_nx == ARM);
      avg_readout_o  <= (state_nx == READOUT);
      done_o         <= (state_nx == DONE);
      avg_shutdown_o <= shutdown_nx;
      busy_o         <= (state_nx != IDLE);
      if (latch) begin
        cfg_rounds  <= (nof_rounds_i == '0) ? CNT_ONE : nof_rounds_i;
        cfg_samples <= (nof_sample_cycles_i == '0) ? CNT_ONE : nof_sample_cycles_i;
        cfg_waves   <= nof_waveforms_i;
        cfg_gap     <= gap_cycles_i;
        cfg_timeout <= timeout_cycles_i;
      end
    end
  end

  assign state_o = state;

`ifdef AVG_SEQ_SWTRIG_EN
  logic [CountWidth-1:0] cfg_period, sw_cnt, sw_nx;
  logic                  sw_pulse;

  always_comb begin
    sw_nx    = sw_cnt;
    sw_pulse = 1'b0;
    if (state == ARM) begin
      sw_nx = '0;
    end else if (state == WAIT_COLLECT) begin
      sw_nx = sw_cnt + 1'b1;
      if ((cfg_period != '0) && (sw_nx == cfg_period)) begin
        sw_pulse = 1'b1;
        sw_nx    = '0;
      end
    end
    // Suppress a pulse that would land in the cycle after leaving the wait.
    if (state_nx != WAIT_COLLECT) sw_pulse = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_period <= '0;
      sw_cnt     <= '0;
      sw_trig_o  <= 1'b0;
    end else begin
      sw_cnt    <= sw_nx;
      sw_trig_o <= sw_pulse;
      if (latch) cfg_period <= swtrig_period_i;
    end
  end
`endif

endmodule

// File: tb/tb_average_round_sequencer.sv
// Self-checking bench for average_round_sequencer: table of directed runs,
// randomized runs against a round-level model, and hand sequences for
// start/abort priority, async reset mid-run and the optional software trigger.
module tb_average_round_sequencer;
  localparam int CW = 16;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start, abort, avail, valid;
  logic [CW-1:0] nof_rounds, nof_waveforms, nof_sample_cycles, gap_cycles, recs;
  logic [TW-1:0] timeout_cycles;
  logic          avg_arm, avg_readout, avg_shutdown, busy, done, timeout_flag;
  logic [CW-1:0] round_count;
  logic [2:0]    state;
`ifdef AVG_SEQ_SWTRIG_EN
  logic [CW-1:0] swtrig_period;
  logic          sw_trig;
`endif

  always #5 clk = ~clk;

  average_round_sequencer #(.TimeoutWidth(TW), .CountWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .nof_rounds_i(nof_rounds), .nof_waveforms_i(nof_waveforms),
    .nof_sample_cycles_i(nof_sample_cycles), .gap_cycles_i(gap_cycles),
    .timeout_cycles_i(timeout_cycles),
    .avg_data_available_i(avail), .avg_records_collected_i(recs),
    .avg_data_valid_i(valid),
`ifdef AVG_SEQ_SWTRIG_EN
    .swtrig_period_i(swtrig_period), .sw_trig_o(sw_trig),
`endif
    .avg_arm_o(avg_arm), .avg_readout_o(avg_readout), .avg_shutdown_o(avg_shutdown),
    .busy_o(busy), .done_o(done), .timeout_o(timeout_flag),
    .round_count_o(round_count), .state_o(state)
  );

  typedef struct {
    int rounds, waves, samples, gap, timeout;
    int hang, abort_beat, meddle;
    int e_arms, e_reads, e_dones, e_shut, e_gap, e_rounds, e_tmo, e_wd;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({state, busy, avg_arm, avg_readout, avg_shutdown, done, timeout_flag, round_count});
  endfunction

  // One full run with a behavioural averager: after each arm it waits a random
  // delay, first reports too few records, then enough; during readout it
  // supplies beats with random bubbles. Strobes and states are tallied.
  task automatic run_vec(input string tag, input vec_t v);
    int arms = 0, reads = 0, dones = 0, shuts = 0, gapc = 0, early = 0;
    int wc_k = -1, shut_k = -1, abort_k = -1, driven = 0, beats_left = 0;
    int cdelay = 0, shortc = 0, rc1 = -1, tmo1 = -1, arm1 = -1, prev = 0, smp;
    bit collecting = 0, suff = 0, aborted = 0, ended = 0;
    smp = (v.samples == 0) ? 1 : v.samples;
    @(negedge clk);
    nof_rounds = CW'(v.rounds); nof_waveforms = CW'(v.waves);
    nof_sample_cycles = CW'(v.samples); gap_cycles = CW'(v.gap);
    timeout_cycles = TW'(v.timeout); start = 1'b1;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rc1 = int'(round_count); tmo1 = int'(timeout_flag); arm1 = int'(avg_arm);
      end
      if (avg_arm) begin
        arms++; collecting = 1; suff = 0;
        cdelay = int'($urandom_range(0, 3)); shortc = (v.waves > 0) ? 2 : 0;
      end
      if (avg_readout) begin
        reads++; if (!suff) early++;
        collecting = 0; suff = 0; beats_left = smp;
      end
      if (avg_shutdown) begin shuts++; shut_k = k; end
      if (done) dones++;
      if (state == 3'd5) gapc++;
      if (state == 3'd2 && prev != 2 && wc_k < 0) wc_k = k;
      prev = int'(state);
      if (state == 3'd0) begin ended = 1; break; end
      start = 1'b0; abort = 1'b0; valid = 1'b0; avail = 1'b0; recs = '0;
      if (v.meddle != 0 && (k == 2 || k == 6)) begin
        start = 1'b1; nof_rounds = 9; nof_waveforms = 1; nof_sample_cycles = 1;
        gap_cycles = 0; timeout_cycles = 3;
      end
      if (collecting && v.hang == 0) begin
        if (cdelay > 0) cdelay--;
        else if (shortc > 0) begin avail = 1'b1; recs = CW'(v.waves - 1); shortc--; end
        else begin avail = 1'b1; recs = CW'(v.waves + int'($urandom_range(0, 2))); suff = 1; end
      end
      if (state == 3'd4 && beats_left > 0) begin
        if (v.abort_beat > 0 && !aborted && driven == v.abort_beat) begin
          abort = 1'b1; aborted = 1; abort_k = k;
        end else if ($urandom_range(0, 3) != 0) begin
          valid = 1'b1; beats_left--; driven++;
        end
      end
    end
    start = 1'b0; abort = 1'b0; valid = 1'b0; avail = 1'b0; recs = '0;
    chk({tag, "/run_ended"}, int'(ended), 1);
    chk({tag, "/arm_after_start"}, arm1, 1);
    chk({tag, "/rounds_cleared"}, rc1, 0);
    chk({tag, "/timeout_cleared"}, tmo1, 0);
    chk({tag, "/arms"}, arms, v.e_arms);
    chk({tag, "/readouts"}, reads, v.e_reads);
    chk({tag, "/early_readouts"}, early, 0);
    chk({tag, "/dones"}, dones, v.e_dones);
    chk({tag, "/shutdowns"}, shuts, v.e_shut);
    chk({tag, "/gap_cycles"}, gapc, v.e_gap);
    chk({tag, "/round_count"}, int'(round_count), v.e_rounds);
    chk({tag, "/timeout_flag"}, int'(timeout_flag), v.e_tmo);
    chk({tag, "/busy_final"}, int'(busy), 0);
    if (v.e_wd >= 0) chk({tag, "/watchdog_latency"}, shut_k - wc_k, v.e_wd);
    if (v.abort_beat > 0) chk({tag, "/abort_to_shutdown"}, shut_k - abort_k, 1);
  endtask

  vec_t vecs[6];

  initial begin
    int seen, cnt;
    start = 0; abort = 0; avail = 0; valid = 0; recs = '0;
    nof_rounds = '0; nof_waveforms = '0; nof_sample_cycles = '0;
    gap_cycles = '0; timeout_cycles = '0;
`ifdef AVG_SEQ_SWTRIG_EN
    swtrig_period = '0;
`endif
    // rounds,waves,samples,gap,timeout, hang,abort_beat,meddle,
    // arms,reads,dones,shut,gap_cyc,rounds,tmo,wd_latency
    vecs[0] = '{2, 4, 8, 3, 0,     0, 0, 0,   2, 2, 1, 0, 3, 2, 0, -1};
    vecs[1] = '{1, 3, 5, 0, 100,   1, 0, 0,   1, 0, 0, 1, 0, 0, 1, 100};
    vecs[2] = '{2, 4, 8, 3, 0,     0, 13, 0,  2, 2, 0, 1, 3, 1, 0, -1};
    vecs[3] = '{0, 2, 0, 0, 0,     0, 0, 0,   1, 1, 1, 0, 0, 1, 0, -1};
    vecs[4] = '{3, 2, 4, 2, 0,     0, 0, 1,   3, 3, 1, 0, 4, 3, 0, -1};
    vecs[5] = '{3, 1, 2, 0, 500,   0, 0, 0,   3, 3, 1, 0, 0, 3, 0, -1};

    repeat (2) @(negedge clk);
    chk("reset/outputs", all_outs(), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // start together with abort in IDLE: start wins; then abort from ARM; then abort in IDLE.
    @(negedge clk);
    nof_rounds = 1; nof_waveforms = 0; nof_sample_cycles = 1; gap_cycles = 0;
    timeout_cycles = 0; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("start_abort/arm", int'(avg_arm), 1);
    chk("start_abort/shutdown", int'(avg_shutdown), 0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_arm/shutdown", int'(avg_shutdown), 1);
    chk("abort_arm/state", int'(state), 0);
    chk("abort_arm/done", int'(done), 0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_idle/shutdown", int'(avg_shutdown), 0);
    chk("abort_idle/busy", int'(busy), 0);

    // Randomized runs against the round-level model.
    for (int i = 0; i < 25; i++) begin
      vec_t r;
      int nr;
      r.rounds = int'($urandom_range(0, 4)); r.waves = int'($urandom_range(0, 6));
      r.samples = int'($urandom_range(0, 12)); r.gap = int'($urandom_range(0, 4));
      r.timeout = ($urandom_range(0, 1) == 0) ? 0 : 600;
      r.hang = 0; r.abort_beat = 0; r.meddle = int'($urandom_range(0, 1));
      nr = (r.rounds == 0) ? 1 : r.rounds;
      r.e_arms = nr; r.e_reads = nr; r.e_dones = 1; r.e_shut = 0;
      r.e_gap = (nr - 1) * r.gap; r.e_rounds = nr; r.e_tmo = 0; r.e_wd = -1;
      run_vec($sformatf("rnd%0d", i), r);
    end

    // Async reset while in GAP.
    @(negedge clk);
    nof_rounds = 2; nof_waveforms = 0; nof_sample_cycles = 1; gap_cycles = 20;
    timeout_cycles = 0; start = 1'b1;
    @(negedge clk); start = 1'b0; avail = 1'b1; valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (state == 3'd5) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("rst_gap/reached_gap", seen, 1);
    chk("rst_gap/round_before", int'(round_count), 1);
    #2 rst = 1'b1;
    #1 chk("rst_gap/outputs_async", all_outs(), 0);
    avail = 1'b0; valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(avg_arm) + int'(avg_readout) + int'(avg_shutdown) + int'(done) + int'(busy);
    end
    chk("rst_gap/no_strobes_after", cnt, 0);

`ifdef AVG_SEQ_SWTRIG_EN
    begin
      int np = 0, wck = -1;
      int offs[4] = '{0, 0, 0, 0};
      @(negedge clk);
      nof_rounds = 1; nof_waveforms = 1; nof_sample_cycles = 1; gap_cycles = 0;
      timeout_cycles = 35; swtrig_period = 10; start = 1'b1;
      @(negedge clk); start = 1'b0; swtrig_period = 3;
      for (int k = 1; k < 60; k++) begin
        @(negedge clk);
        if (state == 3'd2 && wck < 0) wck = k;
        if (sw_trig) begin
          if (np < 4) offs[np] = k - wck;
          np++;
        end
      end
      chk("swtrig/pulses", np, 3);
      chk("swtrig/first", offs[0], 10);
      chk("swtrig/second", offs[1], 20);
      chk("swtrig/third", offs[2], 30);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
